// File: rtl/mem_lsu_stage.sv
// MEM pipeline stage: registered ALU pass-through plus load/store over a req/ack
// data-memory bus, with lane alignment, extension, stall and exception reporting.
module mem_lsu_stage #(
  parameter int unsigned DATA_W     = 32,
  parameter int unsigned ADDR_W     = 32,
  parameter int unsigned REG_ADDR_W = 5,
  parameter int unsigned TIMEOUT    = 16
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      valid_i,
  input  logic [REG_ADDR_W-1:0]     waddr_reg_i,
  input  logic                      we_reg_i,
  input  logic [DATA_W-1:0]         wdata_i,
  input  logic [3:0]                mem_op_i,
  input  logic [ADDR_W-1:0]         mem_addr_i,
  input  logic [DATA_W-1:0]         mem_sdata_i,
  output logic                      stall_o,
  output logic                      valid_o,
  output logic [REG_ADDR_W-1:0]     waddr_reg_o,
  output logic                      we_reg_o,
  output logic [DATA_W-1:0]         wdata_o,
  output logic                      exc_o,
  output logic [1:0]                exc_code_o,
  output logic                      dm_req_o,
  output logic                      dm_we_o,
  output logic [ADDR_W-1:0]         dm_addr_o,
  output logic [DATA_W/8-1:0]       dm_be_o,
  output logic [DATA_W-1:0]         dm_wdata_o,
  input  logic [DATA_W-1:0]         dm_rdata_i,
  input  logic                      dm_ack_i
);

  localparam int unsigned BE_W  = DATA_W / 8;
  localparam int unsigned OFS_W = $clog2(BE_W);
  localparam int unsigned CNT_W = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;

  localparam logic [3:0] OP_NONE = 4'd0;
  localparam logic [3:0] OP_LB   = 4'd1;
  localparam logic [3:0] OP_LBU  = 4'd2;
  localparam logic [3:0] OP_LH   = 4'd3;
  localparam logic [3:0] OP_LHU  = 4'd4;
  localparam logic [3:0] OP_LW   = 4'd5;
  localparam logic [3:0] OP_LWU  = 4'd6;
  localparam logic [3:0] OP_LD   = 4'd7;
  localparam logic [3:0] OP_SB   = 4'd8;
  localparam logic [3:0] OP_SH   = 4'd9;
  localparam logic [3:0] OP_SW   = 4'd10;
  localparam logic [3:0] OP_SD   = 4'd11;

  localparam logic [1:0] EXC_NONE    = 2'd0;
  localparam logic [1:0] EXC_MISALGN = 2'd1;
  localparam logic [1:0] EXC_TIMEOUT = 2'd2;
  localparam logic [1:0] EXC_ILLEGAL = 2'd3;

  typedef enum logic {IDLE, BUSY} state_t;

  state_t               state;
  logic [CNT_W-1:0]     cnt;
  logic                 cap_load;
  logic                 cap_signed;
  logic [1:0]           cap_size;
  logic [OFS_W-1:0]     cap_ofs;
  logic [REG_ADDR_W-1:0] cap_waddr;
  logic                 cap_we;

  // Opcode decode: access size (log2 bytes), direction, signedness, legality.
  logic [1:0] op_size;
  logic       op_load;
  logic       op_store;
  logic       op_signed;
  logic       op_illegal;

  always_comb begin
    op_size    = 2'd0;
    op_load    = 1'b0;
    op_store   = 1'b0;
    op_signed  = 1'b0;
    op_illegal = 1'b0;
    case (mem_op_i)
      OP_NONE: ;
      OP_LB:   begin op_load = 1'b1; op_signed = 1'b1; end
      OP_LBU:  op_load = 1'b1;
      OP_LH:   begin op_load = 1'b1; op_signed = 1'b1; op_size = 2'd1; end
      OP_LHU:  begin op_load = 1'b1; op_size = 2'd1; end
      OP_LW:   begin op_load = 1'b1; op_signed = 1'b1; op_size = 2'd2; end
      OP_LWU:  begin op_load = 1'b1; op_size = 2'd2; op_illegal = (DATA_W == 32); end
      OP_LD:   begin op_load = 1'b1; op_size = 2'd3; op_illegal = (DATA_W == 32); end
      OP_SB:   op_store = 1'b1;
      OP_SH:   begin op_store = 1'b1; op_size = 2'd1; end
      OP_SW:   begin op_store = 1'b1; op_size = 2'd2; end
      OP_SD:   begin op_store = 1'b1; op_size = 2'd3; op_illegal = (DATA_W == 32); end
      default: op_illegal = 1'b1;
    endcase
  end

  logic [OFS_W-1:0] ofs;
  logic             misaligned;
  logic             mem_op;
  logic             start_mem;
  logic             timeout_hit;

  assign ofs         = mem_addr_i[OFS_W-1:0];
  assign misaligned  = (ofs & OFS_W'((32'd1 << op_size) - 32'd1)) != '0;
  assign mem_op      = op_load | op_store;
  assign start_mem   = valid_i && !op_illegal && mem_op && !misaligned;
  assign timeout_hit = (TIMEOUT != 0) && (cnt == CNT_W'(TIMEOUT - 1));
  assign stall_o     = (state == IDLE) ? start_mem : !(dm_ack_i || timeout_hit);

  // Bus payload: lane byte enables and store datum replicated to every lane.
  logic [BE_W-1:0]   be_next;
  logic [DATA_W-1:0] st_rep;

  assign be_next = BE_W'((32'd1 << (32'd1 << op_size)) - 32'd1) << ofs;

  always_comb begin
    st_rep = '0;
    for (int unsigned i = 0; i < BE_W; i++) begin
      st_rep[8*i +: 8] = mem_sdata_i[8*(i & ((32'd1 << op_size) - 32'd1)) +: 8];
    end
  end

  // Load lane extraction: right-justify the lane, then sign/zero extend.
  logic [DATA_W-1:0] ld_shift;
  logic [DATA_W-1:0] ld_left;
  logic [DATA_W-1:0] ld_data;
  int unsigned       ld_sa;

  always_comb begin
    ld_shift = dm_rdata_i >> {cap_ofs, 3'b000};
    ld_sa    = 0;
    if ((32'd8 << cap_size) < DATA_W) ld_sa = DATA_W - (32'd8 << cap_size);
    ld_left  = ld_shift << ld_sa;
    ld_data  = cap_signed ? DATA_W'($signed(ld_left) >>> ld_sa) : (ld_left >> ld_sa);
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state       <= IDLE;
      cnt         <= '0;
      cap_load    <= 1'b0;
      cap_signed  <= 1'b0;
      cap_size    <= 2'd0;
      cap_ofs     <= '0;
      cap_waddr   <= '0;
      cap_we      <= 1'b0;
      valid_o     <= 1'b0;
      waddr_reg_o <= '0;
      we_reg_o    <= 1'b0;
      wdata_o     <= '0;
      exc_o       <= 1'b0;
      exc_code_o  <= EXC_NONE;
      dm_req_o    <= 1'b0;
      dm_we_o     <= 1'b0;
      dm_addr_o   <= '0;
      dm_be_o     <= '0;
      dm_wdata_o  <= '0;
    end else begin
      valid_o    <= 1'b0;
      we_reg_o   <= 1'b0;
      exc_o      <= 1'b0;
      exc_code_o <= EXC_NONE;
      case (state)
        IDLE: begin
          if (valid_i) begin
            if (op_illegal || (mem_op && misaligned)) begin
              valid_o     <= 1'b1;
              waddr_reg_o <= waddr_reg_i;
              wdata_o     <= '0;
              exc_o       <= 1'b1;
              exc_code_o  <= op_illegal ? EXC_ILLEGAL : EXC_MISALGN;
            end else if (!mem_op) begin
              valid_o     <= 1'b1;
              waddr_reg_o <= waddr_reg_i;
              we_reg_o    <= we_reg_i;
              wdata_o     <= wdata_i;
            end else begin
              state      <= BUSY;
              cnt        <= '0;
              dm_req_o   <= 1'b1;
              dm_we_o    <= op_store;
              dm_addr_o  <= {mem_addr_i[ADDR_W-1:OFS_W], OFS_W'(0)};
              dm_be_o    <= be_next;
              dm_wdata_o <= st_rep;
              cap_load   <= op_load;
              cap_signed <= op_signed;
              cap_size   <= op_size;
              cap_ofs    <= ofs;
              cap_waddr  <= waddr_reg_i;
              cap_we     <= we_reg_i;
            end
          end
        end
        BUSY: begin
          // Ack takes priority over a timeout expiring in the same cycle.
          if (dm_ack_i) begin
            state       <= IDLE;
            dm_req_o    <= 1'b0;
            valid_o     <= 1'b1;
            waddr_reg_o <= cap_waddr;
            we_reg_o    <= cap_load & cap_we;
            wdata_o     <= cap_load ? ld_data : '0;
          end else if (timeout_hit) begin
            state       <= IDLE;
            dm_req_o    <= 1'b0;
            valid_o     <= 1'b1;
            waddr_reg_o <= cap_waddr;
            wdata_o     <= '0;
            exc_o       <= 1'b1;
            exc_code_o  <= EXC_TIMEOUT;
          end else begin
            cnt <= cnt + CNT_W'(1);
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mem_lsu_stage.sv
// Directed bench for mem_lsu_stage (DATA_W=32, TIMEOUT=4) with hand-computed expectations.
module tb_mem_lsu_stage;

  logic        clk = 1'b0;
  logic        rst;
  logic        valid_i;
  logic [4:0]  waddr_reg_i;
  logic        we_reg_i;
  logic [31:0] wdata_i;
  logic [3:0]  mem_op_i;
  logic [31:0] mem_addr_i;
  logic [31:0] mem_sdata_i;
  logic        stall_o;
  logic        valid_o;
  logic [4:0]  waddr_reg_o;
  logic        we_reg_o;
  logic [31:0] wdata_o;
  logic        exc_o;
  logic [1:0]  exc_code_o;
  logic        dm_req_o;
  logic        dm_we_o;
  logic [31:0] dm_addr_o;
  logic [3:0]  dm_be_o;
  logic [31:0] dm_wdata_o;
  logic [31:0] dm_rdata_i;
  logic        dm_ack_i;

  int n_cmp = 0;
  int n_bad = 0;
  int stalls;
  int reqs;

  mem_lsu_stage #(
    .DATA_W(32), .ADDR_W(32), .REG_ADDR_W(5), .TIMEOUT(4)
  ) dut (
    .clk(clk), .rst(rst), .valid_i(valid_i), .waddr_reg_i(waddr_reg_i),
    .we_reg_i(we_reg_i), .wdata_i(wdata_i), .mem_op_i(mem_op_i),
    .mem_addr_i(mem_addr_i), .mem_sdata_i(mem_sdata_i), .stall_o(stall_o),
    .valid_o(valid_o), .waddr_reg_o(waddr_reg_o), .we_reg_o(we_reg_o),
    .wdata_o(wdata_o), .exc_o(exc_o), .exc_code_o(exc_code_o),
    .dm_req_o(dm_req_o), .dm_we_o(dm_we_o), .dm_addr_o(dm_addr_o),
    .dm_be_o(dm_be_o), .dm_wdata_o(dm_wdata_o), .dm_rdata_i(dm_rdata_i),
    .dm_ack_i(dm_ack_i)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic [3:0] op, input logic [31:0] addr, input logic [31:0] wd,
                       input logic [31:0] sd, input logic [4:0] wa, input logic we);
    valid_i     = 1'b1;
    mem_op_i    = op;
    mem_addr_i  = addr;
    wdata_i     = wd;
    mem_sdata_i = sd;
    waddr_reg_i = wa;
    we_reg_i    = we;
  endtask

  task automatic idle_in;
    valid_i  = 1'b0;
    mem_op_i = 4'd0;
    we_reg_i = 1'b0;
  endtask

  initial begin
    rst = 1'b0;
    valid_i = 1'b0; waddr_reg_i = '0; we_reg_i = 1'b0; wdata_i = '0;
    mem_op_i = '0; mem_addr_i = '0; mem_sdata_i = '0;
    dm_rdata_i = '0; dm_ack_i = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check("rst_valid", 64'(valid_o), 64'd0);
    check("rst_req", 64'(dm_req_o), 64'd0);
    check("rst_wdata", 64'(wdata_o), 64'd0);
    check("rst_be", 64'(dm_be_o), 64'd0);
    @(negedge clk);
    rst = 1'b1;
    tick();

    // Pass-through of a non-memory op
    drive(4'd0, 32'h0, 32'hDEADBEEF, 32'h0, 5'd3, 1'b1);
    #1 check("pt_stall", 64'(stall_o), 64'd0);
    tick();
    idle_in();
    check("pt_valid", 64'(valid_o), 64'd1);
    check("pt_waddr", 64'(waddr_reg_o), 64'd3);
    check("pt_we", 64'(we_reg_o), 64'd1);
    check("pt_wdata", 64'(wdata_o), 64'hDEADBEEF);
    check("pt_exc", 64'(exc_o), 64'd0);
    #1 check("pt_stall2", 64'(stall_o), 64'd0);
    tick();
    check("bubble_valid", 64'(valid_o), 64'd0);

    // LB at byte 3 with three wait cycles
    drive(4'd1, 32'h1003, 32'h0, 32'h0, 5'd7, 1'b1);
    stalls = 0;
    #1 if (stall_o) stalls++;
    tick();
    check("lb_req", 64'(dm_req_o), 64'd1);
    check("lb_addr", 64'(dm_addr_o), 64'h1000);
    check("lb_be", 64'(dm_be_o), 64'h8);
    check("lb_we", 64'(dm_we_o), 64'd0);
    check("lb_valid_busy", 64'(valid_o), 64'd0);
    for (int k = 0; k < 3; k++) begin
      if (stall_o) stalls++;
      tick();
    end
    check("lb_req_held", 64'(dm_req_o), 64'd1);
    dm_ack_i = 1'b1;
    dm_rdata_i = 32'h80FF_1234;
    #1 if (stall_o) stalls++;
    check("lb_stall_cycles", 64'(stalls), 64'd4);
    tick();
    dm_ack_i = 1'b0;
    idle_in();
    check("lb_valid", 64'(valid_o), 64'd1);
    check("lb_wdata", 64'(wdata_o), 64'hFFFF_FF80);
    check("lb_we_reg", 64'(we_reg_o), 64'd1);
    check("lb_waddr", 64'(waddr_reg_o), 64'd7);
    check("lb_exc", 64'(exc_o), 64'd0);
    check("lb_req_done", 64'(dm_req_o), 64'd0);

    // SH at halfword 1 with immediate ack
    drive(4'd9, 32'h2002, 32'h0, 32'h0000_ABCD, 5'd2, 1'b1);
    tick();
    check("sh_be", 64'(dm_be_o), 64'hC);
    check("sh_wdata", 64'(dm_wdata_o), 64'hABCD_ABCD);
    check("sh_dm_we", 64'(dm_we_o), 64'd1);
    check("sh_addr", 64'(dm_addr_o), 64'h2000);
    dm_ack_i = 1'b1;
    #1 check("sh_stall_ack", 64'(stall_o), 64'd0);
    tick();
    dm_ack_i = 1'b0;
    idle_in();
    check("sh_valid", 64'(valid_o), 64'd1);
    check("sh_we_reg", 64'(we_reg_o), 64'd0);
    check("sh_wdata_o", 64'(wdata_o), 64'd0);

    // LH sign extension from the low halfword
    drive(4'd3, 32'h0000_0010, 32'h0, 32'h0, 5'd9, 1'b1);
    tick();
    check("lh_be", 64'(dm_be_o), 64'h3);
    dm_ack_i = 1'b1;
    dm_rdata_i = 32'h1234_F00D;
    tick();
    dm_ack_i = 1'b0;
    idle_in();
    check("lh_wdata", 64'(wdata_o), 64'hFFFF_F00D);

    // Misaligned LW
    drive(4'd5, 32'h2001, 32'h0, 32'h0, 5'd1, 1'b1);
    #1 check("lw_mis_stall", 64'(stall_o), 64'd0);
    tick();
    idle_in();
    check("lw_mis_valid", 64'(valid_o), 64'd1);
    check("lw_mis_exc", 64'(exc_o), 64'd1);
    check("lw_mis_code", 64'(exc_code_o), 64'd1);
    check("lw_mis_we", 64'(we_reg_o), 64'd0);
    check("lw_mis_req", 64'(dm_req_o), 64'd0);

    // LD and code 14 are illegal at DATA_W=32
    drive(4'd7, 32'h2000, 32'h0, 32'h0, 5'd1, 1'b1);
    tick();
    idle_in();
    check("ld_ill_code", 64'(exc_code_o), 64'd3);
    check("ld_ill_exc", 64'(exc_o), 64'd1);
    check("ld_ill_req", 64'(dm_req_o), 64'd0);
    drive(4'd14, 32'h2000, 32'h0, 32'h0, 5'd1, 1'b1);
    tick();
    idle_in();
    check("op14_code", 64'(exc_code_o), 64'd3);

    // LHU with no ack: timeout after four BUSY cycles
    drive(4'd4, 32'h3002, 32'h0, 32'h0, 5'd4, 1'b1);
    tick();
    reqs = 0;
    for (int k = 0; k < 4; k++) begin
      if (dm_req_o) reqs++;
      check($sformatf("to_stall%0d", k), 64'(stall_o), (k < 3) ? 64'd1 : 64'd0);
      tick();
    end
    idle_in();
    check("to_req_cycles", 64'(reqs), 64'd4);
    check("to_valid", 64'(valid_o), 64'd1);
    check("to_exc", 64'(exc_o), 64'd1);
    check("to_code", 64'(exc_code_o), 64'd2);
    check("to_req", 64'(dm_req_o), 64'd0);
    check("to_we", 64'(we_reg_o), 64'd0);

    // LHU with ack on the fourth BUSY cycle: ack wins over the timeout
    drive(4'd4, 32'h3002, 32'h0, 32'h0, 5'd4, 1'b1);
    tick();
    repeat (3) tick();
    check("late_req", 64'(dm_req_o), 64'd1);
    dm_ack_i = 1'b1;
    dm_rdata_i = 32'h8001_5555;
    #1 check("late_stall", 64'(stall_o), 64'd0);
    tick();
    dm_ack_i = 1'b0;
    idle_in();
    check("late_valid", 64'(valid_o), 64'd1);
    check("late_exc", 64'(exc_o), 64'd0);
    check("late_wdata", 64'(wdata_o), 64'h0000_8001);
    check("late_we", 64'(we_reg_o), 64'd1);

    // Reset in the middle of an access; a late ack must be ignored
    drive(4'd5, 32'h4000, 32'h0, 32'h0, 5'd6, 1'b1);
    tick();
    check("mid_req", 64'(dm_req_o), 64'd1);
    idle_in();
    #2 rst = 1'b0;
    #1;
    check("mid_rst_req", 64'(dm_req_o), 64'd0);
    check("mid_rst_valid", 64'(valid_o), 64'd0);
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk);
    #1;
    dm_ack_i = 1'b1;
    dm_rdata_i = 32'h1111_2222;
    tick();
    dm_ack_i = 1'b0;
    check("late_ack_valid", 64'(valid_o), 64'd0);
    check("late_ack_req", 64'(dm_req_o), 64'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/mem_lsu_stage.md
Name: mem_lsu_stage

Overview:
Parametrised memory-access pipeline stage sitting between EX and WB. It passes ALU results through as a registered stage, and adds what the plain pass-through MEM stage lacks:
- load/store execution over a req/ack data-memory bus;
- byte/halfword/word (and doubleword when 64-bit) lanes with sign/zero extension;
- pipeline stall while an access is outstanding;
- misalignment, illegal-op and bus-timeout exceptions.

Parameters:
DATA_W, 32, datapath width; legal values 32 or 64; BE_W = DATA_W/8, OFS_W = log2(BE_W)
ADDR_W, 32, data-memory address width
REG_ADDR_W, 5, register-file address width
TIMEOUT, 16, cycles in BUSY without ack before a bus-timeout exception; 0 disables the timeout

Ports:
clk  in  1  clock, all state on rising edge
rst  in  1  asynchronous, active-low reset
valid_i  in  1  EX stage presents an instruction
waddr_reg_i  in  REG_ADDR_W  destination register
we_reg_i  in  1  register write enable from EX
wdata_i  in  DATA_W  ALU result, used for non-memory ops
mem_op_i  in  4  0 NONE, 1 LB, 2 LBU, 3 LH, 4 LHU, 5 LW, 6 LWU, 7 LD, 8 SB, 9 SH, 10 SW, 11 SD; others illegal
mem_addr_i  in  ADDR_W  effective address
mem_sdata_i  in  DATA_W  store data, right-justified
stall_o  out  1  hold EX inputs stable and freeze upstream
valid_o  out  1  WB entry valid
waddr_reg_o  out  REG_ADDR_W  to WB
we_reg_o  out  1  to WB
wdata_o  out  DATA_W  to WB
exc_o  out  1  exception flag, qualified by valid_o
exc_code_o  out  2  0 none, 1 misaligned, 2 bus timeout, 3 illegal op
dm_req_o  out  1  bus request
dm_we_o  out  1  1 = store
dm_addr_o  out  ADDR_W  address with the low OFS_W bits cleared
dm_be_o  out  BE_W  byte enables
dm_wdata_o  out  DATA_W  store data replicated across lanes
dm_rdata_i  in  DATA_W  read data, valid in the ack cycle
dm_ack_i  in  1  access complete

Behaviour:
- Reset (rst=0, asynchronous): state IDLE, timeout counter 0. All registered outputs 0: valid_o, waddr_reg_o, we_reg_o, wdata_o, exc_o, exc_code_o, dm_req_o, dm_we_o, dm_addr_o, dm_be_o, dm_wdata_o. Reset mid-access abandons the access; any dm_ack_i arriving afterwards in IDLE is ignored.
- FSM states: IDLE, BUSY.
- IDLE with valid_i=0: next edge valid_o=0 (bubble).
- IDLE, non-memory op (NONE): 1-cycle registered pass-through; valid_o=1, outputs = inputs, exc_o=0; stall_o=0.
- IDLE, illegal op: includes codes 12-15, and LWU/LD/SD when DATA_W=32. Next edge valid_o=1, exc_o=1, code 3, we_reg_o=0; no bus access; stall_o=0.
- IDLE, misaligned op: halfword with addr[0]≠0, word with addr[1:0]≠0, doubleword with addr[2:0]≠0. Next edge valid_o=1, exc_o=1, code 1, we_reg_o=0; no bus access.
- IDLE, legal aligned memory op: stall_o=1 combinationally. Next edge: dm_req_o=1; dm_addr_o, dm_we_o, dm_be_o, dm_wdata_o registered; op, lane offset and waddr captured; state BUSY; valid_o=0.
- BUSY: dm_* outputs held constant. stall_o = !dm_ack_i.
- BUSY with dm_ack_i=1: next edge dm_req_o=0, state IDLE, valid_o=1, exc_o=0.
  - Loads: we_reg_o = captured we_reg_i; wdata_o = lane extract of dm_rdata_i at captured offset (little-endian), sign-extended (LB/LH/LW) or zero-extended (LBU/LHU/LWU) to DATA_W.
  - Stores: we_reg_o=0, wdata_o=0.
- BUSY timeout (TIMEOUT≠0): counter increments each BUSY cycle without ack. When it reaches TIMEOUT-1 with no ack: next edge dm_req_o=0, state IDLE, valid_o=1, exc_o=1, code 2, we_reg_o=0, stall_o=0 that cycle. If ack arrives in the same cycle the counter hits TIMEOUT-1, the ack wins.
- Byte enables: one bit per byte, lane set by offset — SB 1 bit, SH 2, SW 4, SD 8. dm_wdata_o = store datum replicated to every lane.
- Throughput: one non-memory op per cycle; memory op minimum 2 cycles (request cycle plus ack cycle). Exactly one valid_o pulse per accepted instruction.
- An instruction is accepted on the edge where valid_i=1 and stall_o=0, or on the edge that enters BUSY.

Test Plan:
- Reset: rst=0 asserted mid-BUSY with dm_req_o=1 -> immediately dm_req_o=0, valid_o=0; ack on the next cycle produces no valid_o.
- Pass-through: NONE, waddr 5'd3, we=1, wdata 32'hDEADBEEF -> one cycle later valid_o=1, waddr_reg_o=3, wdata_o=DEADBEEF; stall_o never 1.
- LB, addr 0x1003, ack after 3 wait cycles, rdata 32'h80FF_1234 -> dm_addr_o 0x1000, dm_be_o 4'b1000; stall_o=1 for 4 cycles; wdata_o 32'hFFFF_FF80, we_reg_o=1.
- SH, addr 0x2002, sdata 0x0000_ABCD, immediate ack -> dm_be_o 4'b1100, dm_wdata_o 32'hABCD_ABCD, dm_we_o=1; valid_o with we_reg_o=0.
- LW, addr 0x2001 -> no dm_req_o; valid_o=1, exc_code_o=1. LD with DATA_W=32 -> exc_code_o=3.
- LHU, TIMEOUT=4, no ack -> dm_req_o high 4 cycles, then exc_code_o=2, stall_o released. Ack on the 4th BUSY cycle -> normal completion instead.
